// File: rtl/key_if_pkg.sv
// Shared types and constants for push-button conditioning and downstream consumers.
// Buttons are active-low: a pressed key reads 0.
package key_if_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'b00,
    StPressChk   = 2'b01,
    StHeld       = 2'b10,
    StReleaseChk = 2'b11
  } key_fsm_e;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Reset value is a parameter so idle-high and idle-low inputs both start quiet.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Synchronises and debounces an active-low button; emits a clean level plus
// one-cycle press and release strobes, all registered.
module key_debounce_pulse
  import key_if_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_state,
  output logic key_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_sync;
  key_fsm_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_state_q;
  logic             key_pulse_q;
  logic             release_pulse_q;

  sync_2ff #(
    .ResetVal(KEY_RELEASED)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (key),
    .q_o  (key_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      key_state_q     <= KEY_RELEASED;
      key_pulse_q     <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      // Strobes default low so each accept yields exactly one cycle.
      key_pulse_q     <= 1'b0;
      release_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (key_sync == KEY_PRESSED) begin
            state_q <= StPressChk;
            cnt_q   <= '0;
          end
        end
        StPressChk: begin
          if (key_sync == KEY_RELEASED) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q     <= StHeld;
            cnt_q       <= '0;
            key_state_q <= KEY_PRESSED;
            key_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StHeld: begin
          if (key_sync == KEY_RELEASED) begin
            state_q <= StReleaseChk;
            cnt_q   <= '0;
          end
        end
        StReleaseChk: begin
          if (key_sync == KEY_PRESSED) begin
            state_q <= StHeld;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            key_state_q     <= KEY_RELEASED;
            release_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_state     = key_state_q;
  assign key_pulse     = key_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse with a short debounce window.
// Expected strobes are queued with their arrival cycle when the key is driven.
module tb_key_debounce_pulse;

  localparam int unsigned N   = 4;
  localparam int          LAT = N + 2;

  typedef struct {
    int cyc;
    bit rel;
  } ev_t;

  logic clk;
  logic rst;
  logic key;
  logic key_state;
  logic key_pulse;
  logic release_pulse;

  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];
  logic led_q;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .key_state    (key_state),
    .key_pulse    (key_pulse),
    .release_pulse(release_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the downstream LED flip stage.
  always @(posedge clk) begin
    if (rst) led_q <= 1'b0;
    else if (key_pulse) led_q <= ~led_q;
  end

  // Strobe monitor: every high strobe cycle must match the head of the queue.
  always @(negedge clk) begin
    if (key_pulse === 1'b1 && release_pulse === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL both_pulses cyc=%0d key_pulse=1 release_pulse=1 required not both", cyc);
    end
    if (key_pulse === 1'b1 || release_pulse === 1'b1) begin
      ev_t ev;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d kp=%b rp=%b required none", cyc, key_pulse,
                 release_pulse);
      end else begin
        ev = exp_q.pop_front();
        if (ev.cyc != cyc || ev.rel !== release_pulse) begin
          n_fail++;
          $display("FAIL pulse_match got cyc=%0d rel=%b required cyc=%0d rel=%b", cyc,
                   release_pulse, ev.cyc, ev.rel);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    key = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (key_state !== 1'b1 || key_pulse !== 1'b0 || release_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got ks=%b kp=%b rp=%b required 1 0 0", i,
                 key_state, key_pulse, release_pulse);
      end
    end
    rst = 1'b0;
    key = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int e0;
    key = 1'b0;
    e0  = cyc + 1;
    exp_q.push_back('{cyc: e0 + LAT, rel: 1'b0});
    for (int i = 0; i < 20; i++) begin
      logic exp_ks;
      @(negedge clk);
      exp_ks = (cyc >= e0 + LAT) ? 1'b0 : 1'b1;
      n_checks++;
      if (key_state !== exp_ks) begin
        n_fail++;
        $display("FAIL press_key_state cyc=%0d got %b required %b", cyc, key_state, exp_ks);
      end
    end
  endtask

  task automatic test_release();
    int e0;
    key = 1'b1;
    e0  = cyc + 1;
    exp_q.push_back('{cyc: e0 + LAT, rel: 1'b1});
    for (int i = 0; i < 10; i++) begin
      logic exp_ks;
      @(negedge clk);
      exp_ks = (cyc >= e0 + LAT) ? 1'b1 : 1'b0;
      n_checks++;
      if (key_state !== exp_ks || key_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL release_state cyc=%0d got ks=%b kp=%b required ks=%b kp=0", cyc,
                 key_state, key_pulse, exp_ks);
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    int         e0;
    pat = 7'b0010010;  // applied MSB first: 0,0,1,0,0,1,0
    for (int i = 6; i >= 0; i--) begin
      key = pat[i];
      @(negedge clk);
    end
    key = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (key_state !== 1'b1) begin
        n_fail++;
        $display("FAIL bounce_key_state cyc=%0d got %b required 1", cyc, key_state);
      end
    end
    key = 1'b0;
    e0  = cyc + 1;
    exp_q.push_back('{cyc: e0 + LAT, rel: 1'b0});
    repeat (10) @(negedge clk);
    n_checks++;
    if (key_state !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_then_press key_state got %b required 0", key_state);
    end
    key = 1'b1;
    e0  = cyc + 1;
    exp_q.push_back('{cyc: e0 + LAT, rel: 1'b1});
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    int e0;
    key = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (key_state !== 1'b1 || key_pulse !== 1'b0 || release_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got ks=%b kp=%b rp=%b required 1 0 0", key_state,
               key_pulse, release_pulse);
    end
    rst = 1'b0;
    e0  = cyc + 1;
    exp_q.push_back('{cyc: e0 + LAT, rel: 1'b0});
    repeat (14) @(negedge clk);
    n_checks++;
    if (key_state !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_press key_state got %b required 0", key_state);
    end
    key = 1'b1;
    e0  = cyc + 1;
    exp_q.push_back('{cyc: e0 + LAT, rel: 1'b1});
    repeat (10) @(negedge clk);
  endtask

  task automatic test_led_integration();
    int   kp_cnt = 0;
    int   rp_cnt = 0;
    int   toggles = 0;
    logic led_prev;
    led_prev = led_q;
    for (int p = 0; p < 3; p++) begin
      for (int phase = 0; phase < 2; phase++) begin
        key = (phase == 0) ? 1'b0 : 1'b1;
        exp_q.push_back('{cyc: cyc + 1 + LAT, rel: (phase == 1)});
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (key_pulse === 1'b1) kp_cnt++;
          if (release_pulse === 1'b1) rp_cnt++;
          if (led_q !== led_prev) toggles++;
          led_prev = led_q;
        end
      end
    end
    n_checks++;
    if (kp_cnt != 3 || rp_cnt != 3 || toggles != 3) begin
      n_fail++;
      $display("FAIL led_integration got kp=%0d rp=%0d toggles=%0d required 3 3 3", kp_cnt,
               rp_cnt, toggles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_debounce();
    test_led_integration();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses got %0d outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
